// File: rtl/fpu_issue_rob_if.sv
// Handshake bundle between the FPU issue/ROB block, its requester,
// its execution units and its result consumer.
interface fpu_issue_rob_if #(
    parameter int N_UNIT = 4,
    parameter int W      = 32,
    parameter int UW     = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [UW-1:0]       in_unit;
    logic [2:0]          in_func3;
    logic [W-1:0]        in_rs1;
    logic [W-1:0]        in_rs2;
    logic [N_UNIT-1:0]   unit_order;
    logic [N_UNIT-1:0]   unit_accepted;
    logic [N_UNIT-1:0]   unit_done;
    logic [W-1:0]        unit_rs1;
    logic [W-1:0]        unit_rs2;
    logic [2:0]          unit_func3;
    logic [N_UNIT*W-1:0] unit_rd;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_rd;
    logic                out_err;

    modport master (
        output in_valid, in_unit, in_func3, in_rs1, in_rs2,
        input  in_ready,
        input  unit_order, unit_rs1, unit_rs2, unit_func3,
        output unit_accepted, unit_done, unit_rd,
        input  out_valid, out_rd, out_err,
        output out_ready
    );

    modport slave (
        input  in_valid, in_unit, in_func3, in_rs1, in_rs2,
        output in_ready,
        output unit_order, unit_rs1, unit_rs2, unit_func3,
        input  unit_accepted, unit_done, unit_rd,
        output out_valid, out_rd, out_err,
        input  out_ready
    );
endinterface

// File: rtl/fpu_issue_rob.sv
// Single-slot issue register feeding N execution units, with a small
// reorder buffer that retires results strictly in request order.
module fpu_issue_rob #(
    parameter int N_UNIT = 4,
    parameter int DEPTH  = 4,
    parameter int W      = 32,
    parameter int UW     = 4
) (
    input logic           clk,
    input logic           rst,
    fpu_issue_rob_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic              iss_valid_q, iss_valid_d;
    logic [UW-1:0]     iss_unit_q, iss_unit_d;
    logic [2:0]        iss_func3_q, iss_func3_d;
    logic [W-1:0]      iss_rs1_q, iss_rs1_d;
    logic [W-1:0]      iss_rs2_q, iss_rs2_d;
    logic [PW-1:0]     iss_tag_q, iss_tag_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  err_q, err_d;
    logic [W-1:0]      rd_q [DEPTH];
    logic [W-1:0]      rd_d [DEPTH];
    logic [N_UNIT-1:0] busy_q, busy_d;
    logic [PW-1:0]     utag_q [N_UNIT];
    logic [PW-1:0]     utag_d [N_UNIT];

    logic              in_rdy, alloc, retire, bad, fire, head_done;
    logic [N_UNIT-1:0] order, take;

    // Out-of-range unit index never reaches a unit; it completes as an error.
    assign bad       = int'(iss_unit_q) >= N_UNIT;
    assign in_rdy    = ~iss_valid_q & (count_q < CW'(DEPTH));
    assign alloc     = bus.in_valid & in_rdy;
    assign head_done = done_q[head_q];
    assign retire    = head_done & bus.out_ready;
    assign take      = order & bus.unit_accepted;
    assign fire      = (|take) | (iss_valid_q & bad);

    always_comb begin
        order = '0;
        for (int k = 0; k < N_UNIT; k++) begin
            order[k] = iss_valid_q & (iss_unit_q == UW'(k)) & ~busy_q[k];
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.unit_order = order;
    assign bus.unit_rs1   = iss_rs1_q;
    assign bus.unit_rs2   = iss_rs2_q;
    assign bus.unit_func3 = iss_func3_q;
    assign bus.out_valid  = head_done;
    assign bus.out_rd     = head_done ? rd_q[head_q] : '0;
    assign bus.out_err    = head_done & err_q[head_q];

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_unit_d  = iss_unit_q;
        iss_func3_d = iss_func3_q;
        iss_rs1_d   = iss_rs1_q;
        iss_rs2_d   = iss_rs2_q;
        iss_tag_d   = iss_tag_q;
        head_d      = head_q;
        tail_d      = tail_q;
        done_d      = done_q;
        err_d       = err_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        utag_d      = utag_q;
        count_d     = count_q + CW'(alloc) - CW'(retire);

        if (fire) iss_valid_d = 1'b0;
        if (alloc) begin
            iss_valid_d    = 1'b1;
            iss_unit_d     = bus.in_unit;
            iss_func3_d    = bus.in_func3;
            iss_rs1_d      = bus.in_rs1;
            iss_rs2_d      = bus.in_rs2;
            iss_tag_d      = tail_q;
            tail_d         = tail_q + 1'b1;
            done_d[tail_q] = 1'b0;
        end
        if (retire) begin
            done_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        if (iss_valid_q & bad) begin
            done_d[iss_tag_q] = 1'b1;
            err_d[iss_tag_q]  = 1'b1;
            rd_d[iss_tag_q]   = '0;
        end
        // A done with nothing outstanding or accepted is stale and dropped.
        for (int k = 0; k < N_UNIT; k++) begin
            if (bus.unit_done[k] & busy_q[k]) begin
                done_d[utag_q[k]] = 1'b1;
                err_d[utag_q[k]]  = 1'b0;
                rd_d[utag_q[k]]   = bus.unit_rd[k*W +: W];
                busy_d[k]         = 1'b0;
            end else if (take[k]) begin
                utag_d[k] = iss_tag_q;
                if (bus.unit_done[k]) begin
                    done_d[iss_tag_q] = 1'b1;
                    err_d[iss_tag_q]  = 1'b0;
                    rd_d[iss_tag_q]   = bus.unit_rd[k*W +: W];
                end else begin
                    busy_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            done_q      <= '0;
            busy_q      <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        iss_unit_q  <= iss_unit_d;
        iss_func3_q <= iss_func3_d;
        iss_rs1_q   <= iss_rs1_d;
        iss_rs2_q   <= iss_rs2_d;
        iss_tag_q   <= iss_tag_d;
        err_q       <= err_d;
        rd_q        <= rd_d;
        utag_q      <= utag_d;
    end
endmodule

// File: doc/fpu_issue_rob.md
FPU_ISSUE_ROB -- requirements
Module: fpu_issue_rob

Interface
REQ-001 Parameter N_UNIT, default 4, number of attached execution units (1..16).
REQ-002 Parameter DEPTH, default 4, reorder-buffer entries (power of 2, 2..16).
REQ-003 Parameter W, default 32, operand/result width.
REQ-004 Parameter UW, default 4, width of unit select field (2^UW >= N_UNIT).
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid / in_ready  in / out  1 / 1  operation request handshake.
REQ-008 in_unit  in  UW  target unit index; in_func3  in  3  sub-op; in_rs1, in_rs2  in  W  operands.
REQ-009 unit_order  out  N_UNIT  one-hot order to units; unit_accepted, unit_done  in  N_UNIT  per-unit acks.
REQ-010 unit_rs1, unit_rs2  out  W  broadcast operands; unit_func3  out  3  broadcast sub-op.
REQ-011 unit_rd  in  N_UNIT*W  per-unit results, unit k at bits [k*W +: W], valid when unit_done[k].
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake; out_rd  out  W; out_err  out  1.

Function
REQ-013 Transfer on input when in_valid & in_ready; result retires when out_valid & out_ready.
REQ-014 Accepted request allocates ROB entry at tail and loads single issue register (op, unit, tag) same edge.
REQ-015 in_ready = ~issue_valid & (count < DEPTH); full blocks input even if a retire occurs that cycle.
REQ-016 Issue register drives unit_order[unit] = issue_valid & ~busy[unit]; all other unit_order bits 0.
REQ-017 unit_rs1/rs2/func3 always reflect the issue register contents.
REQ-018 Issue register clears on edge where unit_order[u] & unit_accepted[u]; busy[u] set and tag[u] recorded, unless unit_done[u] same cycle.
REQ-019 unit_done[u] while busy[u] (or same cycle as accept) writes unit_rd slice to entry tag[u], marks entry done, clears busy[u].
REQ-020 unit_done[u] with no op outstanding or accepted in that cycle is ignored.
REQ-021 Multiple units may complete in same cycle; all writes land in their own entries.
REQ-022 in_unit >= N_UNIT: no order issued; entry marked done directly from issue register next edge with rd = 0, err = 1.
REQ-023 out_valid = head entry done; out_rd/out_err = head entry fields; results strictly in request order.
REQ-024 Head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH, updated by +alloc -retire.
REQ-025 Minimum latency: request edge t, unit_order at cycle t+1, single-cycle unit done at t+1, out_valid at t+2.
REQ-026 Units of different latency overlap; younger done before older held in ROB until older retires.
REQ-027 out_rd/out_err hold value while out_valid & ~out_ready.

Reset
REQ-028 rst high at an edge: count, head, tail = 0; issue_valid = 0; busy = 0; all entry done flags = 0.
REQ-029 During/after reset: in_ready = 1 (first cycle after), unit_order = 0, out_valid = 0, out_rd = 0, out_err = 0.
REQ-030 Reset mid-operation discards all in-flight ops; unit_done arriving after reset for pre-reset ops is ignored (REQ-020).

Verification
REQ-031 Single op unit 0, 1-cycle unit returns 0x3F800000 -> out_valid 2 cycles after request, out_rd 0x3F800000, out_err 0.
REQ-032 Op A to 8-cycle unit 2, then op B to 1-cycle unit 1 -> B done first but out order A then B, no retire before A.
REQ-033 DEPTH=4, out_ready=0, 4 ops to distinct units -> in_ready 0 after 4th; one retire, in_ready returns following cycle.
REQ-034 Two back-to-back ops to same busy unit -> second unit_order held low until first unit_done, then issued.
REQ-035 in_unit = N_UNIT -> no unit_order, out_valid with out_rd 0, out_err 1, in order with neighbours.
REQ-036 rst asserted with 3 ops in flight, stale unit_done next cycle -> out_valid stays 0, count 0, in_ready 1.
